// File: rtl/mem_ref_sequencer_pkg.sv
// Shared definitions for the memory-reference sequencer: DataPath strobe bit
// indices, default opcodes and the control-step state encoding.
package mem_ref_sequencer_pkg;

  localparam int CTRL_W = 20;

  localparam int CTRL_PCOUT    = 0;
  localparam int CTRL_MARIN    = 1;
  localparam int CTRL_INCPC    = 2;
  localparam int CTRL_ZLOWIN   = 3;
  localparam int CTRL_ZLOWOUT  = 4;
  localparam int CTRL_PCIN     = 5;
  localparam int CTRL_READ     = 6;
  localparam int CTRL_MDRIN    = 7;
  localparam int CTRL_MD_READ  = 8;
  localparam int CTRL_MDROUT   = 9;
  localparam int CTRL_IRIN     = 10;
  localparam int CTRL_GRB      = 11;
  localparam int CTRL_BAOUT    = 12;
  localparam int CTRL_YIN      = 13;
  localparam int CTRL_CSIGNOUT = 14;
  localparam int CTRL_ADD      = 15;
  localparam int CTRL_GRA      = 16;
  localparam int CTRL_RIN      = 17;
  localparam int CTRL_ROUT     = 18;
  localparam int CTRL_WRITE    = 19;

  localparam logic [4:0] OPC_LD  = 5'b00000;
  localparam logic [4:0] OPC_LDI = 5'b00001;
  localparam logic [4:0] OPC_ST  = 5'b00010;

  localparam logic [3:0] STEP_NONE = 4'd15;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_T8,
    ST_ERROR
  } seq_state_t;

  function automatic logic [CTRL_W-1:0] ctrl_bit(input int idx);
    return CTRL_W'(1) << idx;
  endfunction

endpackage

// File: rtl/mem_ref_sequencer_if.sv
// Bundle between the sequencer (master) and the DataPath/memory side (slave).
interface mem_ref_sequencer_if #(
  parameter int OPCODE_W = 5
);
  import mem_ref_sequencer_pkg::*;

  logic                run;
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic [CTRL_W-1:0]   ctrl;
  logic [3:0]          step;
  logic                instr_done;
  logic                illegal_op;
  logic                bus_error;
  logic                busy;

  modport master (
    input  run, opcode, mem_ready,
    output ctrl, step, instr_done, illegal_op, bus_error, busy
  );

  modport slave (
    output run, opcode, mem_ready,
    input  ctrl, step, instr_done, illegal_op, bus_error, busy
  );

endinterface

// File: rtl/mem_ref_sequencer_mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory wait step and flags the
// cycle in which one more wait would exceed wait_max.
module mem_wait_timer #(
  parameter int WAIT_MAX = 8
) (
  input  logic clock,
  input  logic clear,
  input  logic active,
  input  logic ready,
  output logic timeout
);

  logic [7:0] count_q;

  // Held at zero outside wait steps, so every wait step starts from zero
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      count_q <= '0;
    end else if (active && !ready) begin
      count_q <= count_q + 8'd1;
    end else begin
      count_q <= '0;
    end
  end

  assign timeout = active && !ready && (count_q == 8'(WAIT_MAX - 1));

endmodule

// File: rtl/mem_ref_sequencer.sv
// Moore control-step sequencer for ld/ldi/st: fetch, decode and execute with
// memory wait states, wait timeout trapping and illegal-opcode detection.
module mem_ref_sequencer
  import mem_ref_sequencer_pkg::*;
#(
  parameter int                  OPCODE_W = 5,
  parameter logic [OPCODE_W-1:0] OP_LD    = OPCODE_W'(OPC_LD),
  parameter logic [OPCODE_W-1:0] OP_LDI   = OPCODE_W'(OPC_LDI),
  parameter logic [OPCODE_W-1:0] OP_ST    = OPCODE_W'(OPC_ST),
  parameter int                  WAIT_MAX = 8
) (
  input  logic                 clock,
  input  logic                 clear,
  mem_ref_sequencer_if.master  bus
);

  seq_state_t          state_q, state_d;
  logic [OPCODE_W-1:0] op_q;
  logic                is_ld, is_ldi, is_st, op_legal;
  logic                in_wait, timeout;
  seq_state_t          end_state;

  logic [CTRL_W-1:0]   ctrl_c;
  logic [3:0]          step_c;
  logic                done_c, illegal_c;

  assign is_ld    = (op_q == OP_LD);
  assign is_ldi   = (op_q == OP_LDI);
  assign is_st    = (op_q == OP_ST);
  assign op_legal = (bus.opcode == OP_LD) || (bus.opcode == OP_LDI) || (bus.opcode == OP_ST);
  assign in_wait  = (state_q == ST_T1) || (state_q == ST_T7 && is_ld) || (state_q == ST_T8 && is_st);
  assign end_state = bus.run ? ST_T0 : ST_IDLE;

  mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
    .clock   (clock),
    .clear   (clear),
    .active  (in_wait),
    .ready   (bus.mem_ready),
    .timeout (timeout)
  );

  // Opcode is captured on leaving T3 so later IR changes cannot redirect execution
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_T3) op_q <= bus.opcode;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  state_d = bus.run ? ST_T0 : ST_IDLE;
      ST_T0:    state_d = ST_T1;
      ST_T1:    state_d = timeout ? ST_ERROR : (bus.mem_ready ? ST_T2 : ST_T1);
      ST_T2:    state_d = ST_T3;
      ST_T3:    state_d = op_legal ? ST_T4 : end_state;
      ST_T4:    state_d = ST_T5;
      ST_T5:    state_d = ST_T6;
      ST_T6:    state_d = is_ldi ? end_state : ST_T7;
      ST_T7: begin
        if (is_ld) state_d = timeout ? ST_ERROR : (bus.mem_ready ? ST_T8 : ST_T7);
        else       state_d = ST_T8;
      end
      ST_T8: begin
        if (is_st) state_d = timeout ? ST_ERROR : (bus.mem_ready ? end_state : ST_T8);
        else       state_d = end_state;
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Strobes depend only on registered state; the two flag pulses also look at
  // the T3 opcode and the ST write acknowledge
  always_comb begin
    ctrl_c    = '0;
    step_c    = STEP_NONE;
    done_c    = 1'b0;
    illegal_c = 1'b0;
    unique case (state_q)
      ST_T0: begin
        step_c = 4'd0;
        ctrl_c = ctrl_bit(CTRL_PCOUT) | ctrl_bit(CTRL_MARIN) | ctrl_bit(CTRL_INCPC) | ctrl_bit(CTRL_ZLOWIN);
      end
      ST_T1: begin
        step_c = 4'd1;
        ctrl_c = ctrl_bit(CTRL_ZLOWOUT) | ctrl_bit(CTRL_PCIN) | ctrl_bit(CTRL_READ)
               | ctrl_bit(CTRL_MD_READ) | ctrl_bit(CTRL_MDRIN);
      end
      ST_T2: begin
        step_c = 4'd2;
        ctrl_c = ctrl_bit(CTRL_MDROUT) | ctrl_bit(CTRL_IRIN);
      end
      ST_T3: begin
        step_c    = 4'd3;
        illegal_c = !op_legal;
      end
      ST_T4: begin
        step_c = 4'd4;
        ctrl_c = ctrl_bit(CTRL_GRB) | ctrl_bit(CTRL_BAOUT) | ctrl_bit(CTRL_YIN);
      end
      ST_T5: begin
        step_c = 4'd5;
        ctrl_c = ctrl_bit(CTRL_CSIGNOUT) | ctrl_bit(CTRL_ADD) | ctrl_bit(CTRL_ZLOWIN);
      end
      ST_T6: begin
        step_c = 4'd6;
        if (is_ldi) begin
          ctrl_c = ctrl_bit(CTRL_ZLOWOUT) | ctrl_bit(CTRL_GRA) | ctrl_bit(CTRL_RIN);
          done_c = 1'b1;
        end else begin
          ctrl_c = ctrl_bit(CTRL_ZLOWOUT) | ctrl_bit(CTRL_MARIN);
        end
      end
      ST_T7: begin
        step_c = 4'd7;
        if (is_ld) ctrl_c = ctrl_bit(CTRL_READ) | ctrl_bit(CTRL_MD_READ) | ctrl_bit(CTRL_MDRIN);
        else       ctrl_c = ctrl_bit(CTRL_GRA) | ctrl_bit(CTRL_ROUT) | ctrl_bit(CTRL_MDRIN);
      end
      ST_T8: begin
        step_c = 4'd8;
        if (is_st) begin
          ctrl_c = ctrl_bit(CTRL_WRITE);
          done_c = bus.mem_ready;
        end else begin
          ctrl_c = ctrl_bit(CTRL_MDROUT) | ctrl_bit(CTRL_GRA) | ctrl_bit(CTRL_RIN);
          done_c = 1'b1;
        end
      end
      default: begin
        step_c = STEP_NONE;
      end
    endcase
  end

  assign bus.ctrl       = ctrl_c;
  assign bus.step       = step_c;
  assign bus.instr_done = done_c;
  assign bus.illegal_op = illegal_c;
  assign bus.bus_error  = (state_q == ST_ERROR);
  assign bus.busy       = (state_q != ST_IDLE) && (state_q != ST_ERROR);

endmodule

// File: tb/tb_mem_ref_sequencer.sv
// Directed bench for mem_ref_sequencer with WAIT_MAX=4: ldi/ld/st flows,
// wait states, illegal opcode, async clear and wait timeout.
module tb_mem_ref_sequencer;

  localparam logic [19:0] M_T0      = 20'h0000F;
  localparam logic [19:0] M_T1      = 20'h001F0;
  localparam logic [19:0] M_T2      = 20'h00600;
  localparam logic [19:0] M_T4      = 20'h03800;
  localparam logic [19:0] M_T5      = 20'h0C008;
  localparam logic [19:0] M_T6_LDI  = 20'h30010;
  localparam logic [19:0] M_T6_MEM  = 20'h00012;
  localparam logic [19:0] M_T7_LD   = 20'h001C0;
  localparam logic [19:0] M_T7_ST   = 20'h50080;
  localparam logic [19:0] M_T8_LD   = 20'h30200;
  localparam logic [19:0] M_T8_ST   = 20'h80000;

  logic clock = 1'b0;
  logic clear = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  logic [19:0] fetch_ctrl [1:5];

  mem_ref_sequencer_if #(.OPCODE_W(5)) bus ();

  mem_ref_sequencer #(
    .OPCODE_W (5),
    .OP_LD    (5'b00000),
    .OP_LDI   (5'b00001),
    .OP_ST    (5'b00010),
    .WAIT_MAX (4)
  ) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock; samples land on the falling edge, away from the active edge
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    if (bus.instr_done === 1'b1) done_cnt++;
  endtask

  initial begin
    #60000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    fetch_ctrl[1] = M_T1;
    fetch_ctrl[2] = M_T2;
    fetch_ctrl[3] = 20'h0;
    fetch_ctrl[4] = M_T4;
    fetch_ctrl[5] = M_T5;
    bus.run       = 1'b0;
    bus.opcode    = 5'b00000;
    bus.mem_ready = 1'b0;

    // Reset state
    @(negedge clock);
    check_output("rst_step", bus.step, 4'd15);
    check_output("rst_ctrl", bus.ctrl, 20'h0);
    check_output("rst_busy", bus.busy, 1'b0);
    check_output("rst_bus_error", bus.bus_error, 1'b0);
    check_output("rst_instr_done", bus.instr_done, 1'b0);
    check_output("rst_illegal", bus.illegal_op, 1'b0);
    clear = 1'b1;
    tick();
    check_output("idle_hold", bus.step, 4'd15);

    // LDI, zero-wait, one instruction
    $display("[TB] ldi");
    done_cnt = 0;
    bus.opcode = 5'b00001; bus.mem_ready = 1'b1; bus.run = 1'b1;
    tick();
    check_output("ldi_t0_step", bus.step, 4'd0);
    check_output("ldi_t0_ctrl", bus.ctrl, M_T0);
    check_output("ldi_t0_busy", bus.busy, 1'b1);
    bus.run = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_output($sformatf("ldi_t%0d_step", i), bus.step, i);
      check_output($sformatf("ldi_t%0d_ctrl", i), bus.ctrl, fetch_ctrl[i]);
    end
    tick();
    check_output("ldi_t6_step", bus.step, 4'd6);
    check_output("ldi_t6_ctrl", bus.ctrl, M_T6_LDI);
    check_output("ldi_t6_done", bus.instr_done, 1'b1);
    tick();
    check_output("ldi_end_step", bus.step, 4'd15);
    check_output("ldi_end_busy", bus.busy, 1'b0);
    check_output("ldi_done_cnt", done_cnt, 1);

    // LD with 3 wait cycles in T1 and 2 in T7; IR changes after T3
    $display("[TB] ld with waits");
    done_cnt = 0;
    bus.opcode = 5'b00000; bus.mem_ready = 1'b0; bus.run = 1'b1;
    tick();
    check_output("ld_t0_step", bus.step, 4'd0);
    bus.run = 1'b0;
    tick();
    check_output("ld_t1_entry", bus.step, 4'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_output($sformatf("ld_t1_wait%0d", k), bus.step, 4'd1);
    end
    bus.mem_ready = 1'b1;
    tick();
    check_output("ld_t2_step", bus.step, 4'd2);
    bus.mem_ready = 1'b0;
    tick();
    check_output("ld_t3_step", bus.step, 4'd3);
    tick();
    check_output("ld_t4_step", bus.step, 4'd4);
    bus.opcode = 5'b00010;
    tick();
    tick();
    check_output("ld_t6_ctrl", bus.ctrl, M_T6_MEM);
    check_output("ld_t6_done", bus.instr_done, 1'b0);
    tick();
    check_output("ld_t7_step", bus.step, 4'd7);
    check_output("ld_t7_ctrl", bus.ctrl, M_T7_LD);
    tick();
    check_output("ld_t7_wait0", bus.step, 4'd7);
    tick();
    check_output("ld_t7_wait1", bus.step, 4'd7);
    bus.mem_ready = 1'b1;
    tick();
    check_output("ld_t8_step", bus.step, 4'd8);
    check_output("ld_t8_ctrl", bus.ctrl, M_T8_LD);
    check_output("ld_t8_done", bus.instr_done, 1'b1);
    tick();
    check_output("ld_end_step", bus.step, 4'd15);
    check_output("ld_done_cnt", done_cnt, 1);

    // ST zero-wait, run stays high
    $display("[TB] st");
    done_cnt = 0;
    bus.opcode = 5'b00010; bus.mem_ready = 1'b1; bus.run = 1'b1;
    for (int i = 0; i <= 6; i++) tick();
    check_output("st_t6_step", bus.step, 4'd6);
    check_output("st_t6_ctrl", bus.ctrl, M_T6_MEM);
    tick();
    check_output("st_t7_ctrl", bus.ctrl, M_T7_ST);
    tick();
    check_output("st_t8_step", bus.step, 4'd8);
    check_output("st_t8_ctrl", bus.ctrl, M_T8_ST);
    check_output("st_t8_done", bus.instr_done, 1'b1);
    tick();
    check_output("st_next_t0", bus.step, 4'd0);
    check_output("st_done_cnt", done_cnt, 1);

    // Illegal opcode: run=1 loops to T0, run=0 returns to IDLE
    $display("[TB] illegal opcode");
    bus.opcode = 5'b11111;
    tick(); tick(); tick();
    check_output("ill_t3_step", bus.step, 4'd3);
    check_output("ill_t3_pulse", bus.illegal_op, 1'b1);
    check_output("ill_t3_ctrl", bus.ctrl, 20'h0);
    tick();
    check_output("ill_next_t0", bus.step, 4'd0);
    check_output("ill_pulse_end", bus.illegal_op, 1'b0);
    check_output("ill_bus_error", bus.bus_error, 1'b0);
    bus.run = 1'b0;
    tick(); tick(); tick();
    check_output("ill2_t3_pulse", bus.illegal_op, 1'b1);
    tick();
    check_output("ill2_idle", bus.step, 4'd15);
    check_output("ill_done_cnt", done_cnt, 1);

    // Asynchronous clear in the middle of a waiting LD T7
    $display("[TB] async clear");
    bus.opcode = 5'b00000; bus.mem_ready = 1'b1; bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    for (int i = 1; i <= 6; i++) tick();
    bus.mem_ready = 1'b0;
    tick();
    check_output("clr_pre_t7", bus.step, 4'd7);
    #2 clear = 1'b0;
    #1;
    check_output("clr_async_step", bus.step, 4'd15);
    check_output("clr_async_ctrl", bus.ctrl, 20'h0);
    check_output("clr_async_busy", bus.busy, 1'b0);
    @(negedge clock);
    clear = 1'b1; bus.run = 1'b1;
    tick();
    check_output("clr_restart_t0", bus.step, 4'd0);

    // Timeout in T1: four not-ready cycles then ERROR
    $display("[TB] timeout");
    bus.run = 1'b0;
    tick();
    check_output("to_t1_entry", bus.step, 4'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_output($sformatf("to_t1_wait%0d", k), bus.step, 4'd1);
    end
    tick();
    check_output("to_err_step", bus.step, 4'd15);
    check_output("to_err_ctrl", bus.ctrl, 20'h0);
    check_output("to_err_flag", bus.bus_error, 1'b1);
    check_output("to_err_busy", bus.busy, 1'b0);
    bus.mem_ready = 1'b1; bus.run = 1'b1;
    tick(); tick(); tick();
    check_output("to_sticky_flag", bus.bus_error, 1'b1);
    check_output("to_sticky_step", bus.step, 4'd15);
    #2 clear = 1'b0;
    #1;
    check_output("to_clear_flag", bus.bus_error, 1'b0);
    @(negedge clock);
    clear = 1'b1;
    tick();
    check_output("to_after_clear", bus.step, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
